instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Fetch controller that sequences the byte-addressable, big-endian instruction memory: owns the fetch PC, drives the memory address, and captures each 16-bit instruction word into a small prefetch buffer. The buffer feeds decode through a valid/ready handshake. The block sits between the instruction memory (combinational read: address in, {mem[a], mem[a+1]} out) and the decode stage. It also handles branch redirects, halt detection and alignment faults.

## Interface
- `RESET_PC`, 16'h0000, fetch PC loaded at reset
- `HALT_OPCODE`, 16'hFFFF, instruction word that stops fetching
- `DEPTH`, 2, prefetch buffer entries (power of two, ≥2)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  fetch enable; low blocks new fetches, buffer still drains
- `imem_addr`  out  16  byte address to instruction memory (equals fetch PC)
- `imem_data`  in  16  instruction word returned combinationally for `imem_addr`
- `redirect_valid`  in  1  load new fetch PC (branch/jump)
- `redirect_pc`  in  16  redirect target byte address
- `instr_valid`  out  1  buffer head valid
- `instr`  out  16  buffer head instruction word
- `instr_pc`  out  16  byte address of `instr`
- `instr_ready`  in  1  decode accepts head this cycle
- `halted`  out  1  state is HALT
- `fault`  out  1  state is FAULT (alignment error)

## Operation
- States: RUN, HALT, FAULT. Reset state is RUN.
- Reset values:
  - fetch PC = `RESET_PC`, buffer count = 0.
  - `instr_valid`, `halted` and `fault` = 0.
  - `instr` and `instr_pc` = 0.
- Pop: a pop occurs when `instr_valid && instr_ready`.
- Push condition: RUN && `en` && !`redirect_valid` && (count < DEPTH || pop).
- On push:
  - Write {`imem_data`, fetch PC} at the buffer tail.
  - Fetch PC <= fetch PC + 2, wrapping modulo 2^16 (16'hFFFE -> 16'h0000).
- Halt:
  - If the pushed word == `HALT_OPCODE`, it is still buffered, then RUN -> HALT.
  - No further pushes in HALT.
  - Already-buffered entries keep draining.
- Redirect (highest priority, any state):
  - Buffer flushed (count <= 0). Any head presented that cycle is discarded, even if `instr_ready` was high.
  - Fetch PC <= `redirect_pc`.
  - State <= RUN.
  - No push in the redirect cycle.
- Simultaneous push and pop with the buffer full is legal: count is unchanged. This makes a combinational path from `instr_ready` to the push enable.
- `en` low: state is unchanged, no push, pops continue.
- `imem_addr` is driven from the fetch PC in every state. Memory array bounds are not checked here.

## Timing
- Fetch address-to-buffer latency: 1 cycle. A word pushed on edge N shows `instr_valid`=1 after edge N.
- After reset release with `en`=1:
  - First edge pushes `RESET_PC`'s word.
  - `instr_valid` rises one cycle after the first edge.
- Steady state, `instr_ready`=1: one instruction per cycle, consecutive `instr_pc` values +2 apart.
- Redirect at edge N:
  - `instr_valid`=0 during cycle N+1.
  - Target word pushed at edge N+1 (if RUN and `en`).
  - Target word valid in cycle N+2.
  - Redirect-to-valid: 2 cycles.
- `halted` and `fault` are registered and assert the cycle after the triggering edge.
- Asynchronous reset mid-operation: all state returns to reset values immediately. Buffer contents are discarded.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[0]`=1 flushes the buffer, loads the fetch PC unchanged, and enters FAULT (`fault`=1). No pushes occur in FAULT.
  - Only an even-address redirect leaves FAULT (-> RUN, `fault`=0).
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `redirect_pc[0]` is forced to 0 on load.
  - FAULT is unreachable and `fault` is tied 0.

## Test plan
- **Reset fetch:** reset, `en`=1, `instr_ready`=1, memory 0x00..0x05 = D1 18 12 34 AB CD -> `instr`/`instr_pc` sequence D118/0000, 1234/0002, ABCD/0004, one per cycle.
- **Backpressure:** `instr_ready`=0 for 5 cycles -> count saturates at 2, `imem_addr` holds 0x0004, `instr` stays D118. Releasing `instr_ready` -> no word lost or duplicated.
- **Redirect during fill:** redirect to 0x0040 while 2 entries are buffered and `instr_ready`=1 -> `instr_valid`=0 the next cycle, then `instr_pc`=0x0040 two cycles after the redirect. Pre-redirect entries never reappear.
- **Halt:** word FFFF at 0x0006 -> FFFF is delivered with `instr_pc`=0x0006, `halted`=1, `imem_addr` stays 0x0008. Redirect to 0x0000 -> `halted`=0 and fetch resumes.
- **Wrap:** redirect to 0xFFFE -> next `instr_pc` values are 0xFFFE then 0x0000.
- **Alignment (with `FETCH_ALIGN_CHECK_EN`):** redirect to 0x0013 -> `fault`=1, `instr_valid` stays 0. Redirect to 0x0012 -> `fault`=0, word at 0x0012 delivered. Without the macro, redirect to 0x0013 fetches from 0x0012 and `fault` stays 0.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, drives the instruction
// memory address, and buffers fetched 16-bit words for decode behind a
// valid/ready handshake. Handles branch redirects, halt detection and,
// when FETCH_ALIGN_CHECK_EN is defined, odd-address redirect faults.
module instr_fetch_ctrl #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] HALT_OPCODE = 16'hFFFF,
    parameter int          DEPTH       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    output logic        halted,
    output logic        fault
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_FAULT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [15:0]        fetch_pc;
    logic [15:0]        fetch_pc_next;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [15:0]        buf_word [DEPTH];
    logic [15:0]        buf_pc   [DEPTH];
    logic               pop;
    logic               push;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    // A pop frees a slot in the same cycle, so a full buffer can still accept
    // a word; this is the intended combinational path from instr_ready.
    assign push        = (state == ST_RUN) && en && !redirect_valid &&
                         ((count < CNT_W'(DEPTH)) || pop);

    assign imem_addr = fetch_pc;
    assign instr     = instr_valid ? buf_word[head] : '0;
    assign instr_pc  = instr_valid ? buf_pc[head]   : '0;
    assign halted    = (state == ST_HALT);
`ifdef FETCH_ALIGN_CHECK_EN
    assign fault     = (state == ST_FAULT);
`else
    assign fault     = 1'b0;
`endif

    // Next state and next fetch PC: redirect wins over everything, then push.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        state_next    = state;
        fetch_pc_next = fetch_pc;
        if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_pc_next = redirect_pc;
            state_next    = redirect_pc[0] ? ST_FAULT : ST_RUN;
`else
            fetch_pc_next = redirect_pc & 16'hFFFE;
            state_next    = ST_RUN;
`endif
        end else if (push) begin
            fetch_pc_next = fetch_pc + 16'd2;
            if (imem_data == HALT_OPCODE) begin
                state_next = ST_HALT;
            end
        end
    end

    // State and fetch PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state    <= ST_RUN;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    // Buffer occupancy and pointers; a redirect flushes, dropping any head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect_valid) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage written at the tail on every push.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; entries are only visible through
        // instr_valid, which comes from the reset count, and outputs are
        // gated to zero when the buffer is empty.
        if (push) begin
            buf_word[tail] <= imem_data;
            buf_pc[tail]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: a byte-wide memory model feeds
// the DUT and a scoreboard queue holds the words decode should receive.
module tb_instr_fetch_ctrl;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] addr_p1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        halted;
    logic        fault;

    logic [7:0]  mem [0:65535];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;

    instr_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .halted         (halted),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    // Big-endian combinational memory read.
    assign addr_p1   = imem_addr + 16'd1;
    assign imem_data = {mem[imem_addr], mem[addr_p1]};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_word(input logic [15:0] word, input logic [15:0] pc);
        exp_q.push_back('{word: word, pc: pc});
    endtask

    // Compare an accepted head against the scoreboard, then advance one cycle.
    task automatic tick();
        exp_t e;
        if (instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop_pc", instr_pc, 16'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr", instr, e.word);
                check("sb_instr_pc", instr_pc, e.pc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles, output int used);
        used = 0;
        while (exp_q.size() > 0 && used < max_cycles) begin
            tick();
            used++;
        end
        check("sb_drained", 16'(exp_q.size()), 16'd0);
    endtask

    task automatic do_reset(input logic ready_v);
        rst_n          = 1'b0;
        en             = 1'b1;
        redirect_valid = 1'b0;
        instr_ready    = ready_v;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_valid", 16'(instr_valid), 16'd0);
        check("rst_instr", instr, 16'h0000);
        check("rst_instr_pc", instr_pc, 16'h0000);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_halted", 16'(halted), 16'd0);
        check("rst_fault", 16'(fault), 16'd0);
        rst_n = 1'b1;
    endtask

    // One-cycle redirect; discards pending expectations and ends at N+1.
    task automatic redirect(input logic [15:0] pc);
        exp_q.delete();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        check("redir_valid_low", 16'(instr_valid), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'hD1; mem[16'h0001] = 8'h18;
        mem[16'h0002] = 8'h12; mem[16'h0003] = 8'h34;
        mem[16'h0004] = 8'hAB; mem[16'h0005] = 8'hCD;
        mem[16'h0006] = 8'hFF; mem[16'h0007] = 8'hFF;
        mem[16'h0012] = 8'h77; mem[16'h0013] = 8'h88;
        mem[16'h0040] = 8'h5A; mem[16'h0041] = 8'hA5;
        mem[16'h0042] = 8'hC3; mem[16'h0043] = 8'h3C;
        mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h21;

        // Reset fetch through to halt, one word per cycle.
        do_reset(1'b1);
        check("t1_valid_before_edge", 16'(instr_valid), 16'd0);
        expect_word(16'hD118, 16'h0000);
        expect_word(16'h1234, 16'h0002);
        expect_word(16'hABCD, 16'h0004);
        expect_word(16'hFFFF, 16'h0006);
        tick();
        check("t1_first_valid", 16'(instr_valid), 16'd1);
        check("t1_first_pc", instr_pc, 16'h0000);
        drain(20, used);
        check("t1_cycles", 16'(used), 16'd4);
        check("halt_halted", 16'(halted), 16'd1);
        check("halt_addr", imem_addr, 16'h0008);
        check("halt_valid", 16'(instr_valid), 16'd0);
        tick();
        check("halt_addr_hold", imem_addr, 16'h0008);
        check("halt_valid_hold", 16'(instr_valid), 16'd0);

        // Redirect out of HALT resumes fetch.
        redirect(16'h0000);
        check("unhalt", 16'(halted), 16'd0);
        expect_word(16'hD118, 16'h0000);
        expect_word(16'h1234, 16'h0002);
        tick();
        check("unhalt_valid", 16'(instr_valid), 16'd1);
        check("unhalt_pc", instr_pc, 16'h0000);
        drain(10, used);

        // Backpressure: buffer fills to two entries and holds.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i >= 1) begin
                check("bp_addr", imem_addr, 16'h0004);
                check("bp_instr", instr, 16'hD118);
                check("bp_valid", 16'(instr_valid), 16'd1);
            end
        end
        expect_word(16'hD118, 16'h0000);
        expect_word(16'h1234, 16'h0002);
        expect_word(16'hABCD, 16'h0004);
        expect_word(16'hFFFF, 16'h0006);
        instr_ready = 1'b1;
        drain(20, used);
        check("bp_cycles", 16'(used), 16'd4);

        // Redirect while two entries are buffered and decode is ready.
        do_reset(1'b0);
        tick();
        tick();
        instr_ready = 1'b1;
        redirect(16'h0040);
        expect_word(16'h5AA5, 16'h0040);
        expect_word(16'hC33C, 16'h0042);
        expect_word(16'h0000, 16'h0044);
        tick();
        check("redir_valid", 16'(instr_valid), 16'd1);
        check("redir_pc", instr_pc, 16'h0040);
        drain(10, used);

        // Address wrap at the top of memory.
        redirect(16'hFFFE);
        expect_word(16'h1221, 16'hFFFE);
        expect_word(16'hD118, 16'h0000);
        tick();
        drain(10, used);

        // Odd-address redirect.
`ifdef FETCH_ALIGN_CHECK_EN
        redirect(16'h0013);
        check("align_fault", 16'(fault), 16'd1);
        check("align_addr", imem_addr, 16'h0013);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("align_fault_valid", 16'(instr_valid), 16'd0);
            check("align_fault_hold", 16'(fault), 16'd1);
        end
        redirect(16'h0012);
        check("align_clear", 16'(fault), 16'd0);
        expect_word(16'h7788, 16'h0012);
        tick();
        check("align_pc", instr_pc, 16'h0012);
        drain(10, used);
`else
        redirect(16'h0013);
        check("align_nofault", 16'(fault), 16'd0);
        check("align_addr", imem_addr, 16'h0012);
        expect_word(16'h7788, 16'h0012);
        tick();
        check("align_pc", instr_pc, 16'h0012);
        drain(10, used);
`endif

        // Asynchronous reset mid-stream clears state without a clock edge.
        rst_n = 1'b0;
        #1;
        check("async_valid", 16'(instr_valid), 16'd0);
        check("async_addr", imem_addr, 16'h0000);
        check("async_instr", instr, 16'h0000);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
